pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. Every cycle it decides which pipeline registers advance, which ones take a bubble, and whether the PC takes the branch target. It detects load-use hazards, flushes the pipeline on a branch resolved in MEM, and freezes the pipeline while the data memory is slow, using a req/ready handshake with a timeout. It also keeps saturating stall and flush counters.

## Interface
- CNT_W, 16, width of stall_count / flush_count
- MEM_TIMEOUT, 16, consecutive not-ready cycles tolerated before error (≥1)

Ports: clock and reset are `clk`, `reset`. One clock. Reset is synchronous and active-high.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- IF_ID_Rs1, IF_ID_Rs2  in  5 each  source registers of the instruction in ID
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_Rd  in  5  destination of the instruction in EX
- EX_MEM_Branch, EX_MEM_ALU_Zero  in  1 each  branch resolution inputs in MEM
- EX_MEM_MemRead, EX_MEM_MemWrite  in  1 each  MEM-stage memory access
- mem_ready  in  1  data memory completes the access this cycle
- mem_req  out  1  MEM-stage access request
- PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write  out  1 each  register enables
- IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush  out  1 each  load a bubble (control fields zeroed)
- PC_Src  out  1  select the branch target
- mem_error  out  1  sticky memory-timeout flag
- stall_count, flush_count  out  CNT_W each  saturating event counters

## Operation
- FSM states:
  - RUN → MEM_WAIT on an edge with mem_req & !mem_ready.
  - MEM_WAIT → RUN on an edge with mem_ready.
  - MEM_WAIT → ERROR on the edge that completes MEM_TIMEOUT consecutive not-ready cycles.
  - ERROR is left only by reset.
- wait_cnt has width $clog2(MEM_TIMEOUT+1). It clears in RUN and increments on each not-ready edge.
- mem_req = (EX_MEM_MemRead | EX_MEM_MemWrite) & state≠ERROR.
- mem_stall = mem_req & !mem_ready.
- br_taken = EX_MEM_Branch & EX_MEM_ALU_Zero.
- lu_hazard = ID_EX_MemRead & ID_EX_Rd≠0 & (ID_EX_Rd==IF_ID_Rs1 | ID_EX_Rd==IF_ID_Rs2).
- Default: all *_Write=1, all *_Flush=0, PC_Src=0.
- Priority, highest first:
  1. ERROR: all *_Write=0, all flush 0, PC_Src=0, mem_req=0.
  2. mem_stall: PC/IF_ID/ID_EX/EX_MEM _Write=0; MEM_WB_Write=1 with MEM_WB_Flush=1 (bubble into WB). Branch and load-use are ignored; the inputs stay frozen, so they are re-evaluated when the stall ends.
  3. br_taken: PC_Src=1, IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1, all writes 1. A simultaneous lu_hazard is ignored because the stalled instruction is discarded.
  4. lu_hazard: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; others default.
- stall_count increments on every non-ERROR cycle with PC_Write=0 (mem_stall or lu_hazard). It saturates at all-ones.
- flush_count increments once per cycle in which priority 3 is active. It saturates at all-ones.
- mem_error = (state==ERROR).

## Timing
- All control outputs and mem_req are combinational from the current inputs and state, with zero latency. State, wait_cnt and the counters update at posedge clk.
- Handshake: mem_ready is meaningful only while mem_req=1. Completion takes effect in the cycle mem_ready=1, and the pipeline advances at that edge. An access answered in its first cycle costs 0 stall cycles; ready after N cycles costs N stall cycles.
- Timeout: ready arriving in stall cycle MEM_TIMEOUT+1 is too late. mem_error rises the cycle after the MEM_TIMEOUT-th not-ready cycle.
- While reset=1: all *_Write=0, flushes=0, PC_Src=0, mem_req=0.
- Values after the reset edge: state=RUN, wait_cnt=0, mem_error=0, counters=0.
- Reset mid-MEM_WAIT or in ERROR returns to RUN at that edge with no residual stall.

## Test plan
- Load-use: ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_Rs2=5 → PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for one cycle; stall_count=1. Repeat with Rd=0 → no stall.
- Branch: EX_MEM_Branch=1, ALU_Zero=1 with a concurrent load-use → PC_Src=1, IF_ID/ID_EX/EX_MEM flush=1, PC_Write=1; flush_count=1, stall_count unchanged. With ALU_Zero=0 → defaults.
- Memory wait: EX_MEM_MemRead=1, mem_ready low for 3 cycles then high → 3 frozen cycles with MEM_WB_Flush=1; advance on the 4th; stall_count=3, state back to RUN.
- Timeout: MEM_TIMEOUT=16, mem_ready held 0 → mem_error=1 from cycle 17; all writes 0 and mem_req=0. A later mem_ready=1 has no effect. Reset clears mem_error and the counters to 0.
- Stall priority: MemWrite with mem_ready=0 plus ID_EX load-use → only the memory-stall pattern appears. Release ready → load-use is applied the next cycle.
- Saturation: CNT_W=4, 20 load-use cycles → stall_count stays at 15.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/PC-select controller for a 5-stage RISC-V pipeline.
// Resolves load-use hazards, MEM-stage branches and slow data-memory accesses with a timeout.
module pipeline_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_Rs1,
    input  logic [4:0]       IF_ID_Rs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             EX_MEM_Branch,
    input  logic             EX_MEM_ALU_Zero,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             MEM_WB_Flush,
    output logic             PC_Src,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_next;
    logic [CNT_W-1:0]   r_stall_count;
    logic [CNT_W-1:0]   r_flush_count;

    logic w_mem_access;
    logic w_mem_stall;
    logic w_br_taken;
    logic w_lu_hazard;
    logic w_stall_evt;
    logic w_flush_evt;

    // Reset and ERROR both silence the memory request, so a stall can never be seen in either.
    assign w_mem_access = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~reset & (r_state != ST_ERROR);
    assign w_mem_stall  = w_mem_access & ~mem_ready;
    assign w_br_taken   = EX_MEM_Branch & EX_MEM_ALU_Zero;
    assign w_lu_hazard  = ID_EX_MemRead & (ID_EX_Rd != 5'd0) &
                          ((ID_EX_Rd == IF_ID_Rs1) | (ID_EX_Rd == IF_ID_Rs2));

    assign mem_req     = w_mem_access;
    assign mem_error   = (r_state == ST_ERROR);
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        MEM_WB_Write = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        MEM_WB_Flush = 1'b0;
        PC_Src       = 1'b0;
        w_stall_evt  = 1'b0;
        w_flush_evt  = 1'b0;

        if (reset || (r_state == ST_ERROR)) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Write = 1'b0;
        end else if (w_mem_stall) begin
            // Freeze everything up to MEM and drain a bubble into WB.
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Flush = 1'b1;
            w_stall_evt  = 1'b1;
        end else if (w_br_taken) begin
            PC_Src       = 1'b1;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            w_flush_evt  = 1'b1;
        end else if (w_lu_hazard) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Flush  = 1'b1;
            w_stall_evt  = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        case (r_state)
            ST_RUN, ST_MEM_WAIT: begin
                if (w_mem_stall) begin
                    w_wait_next  = r_wait_cnt + WAIT_W'(1);
                    w_state_next = (w_wait_next == WAIT_LIMIT) ? ST_ERROR : ST_MEM_WAIT;
                end else begin
                    w_wait_next  = '0;
                    w_state_next = ST_RUN;
                end
            end
            ST_ERROR: w_state_next = ST_ERROR;
            default: begin
                w_state_next = ST_RUN;
                w_wait_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            if (w_stall_evt && (r_stall_count != CNT_MAX)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_count != CNT_MAX)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: two differently-parameterised controllers driven by shared stimulus and
// checked every cycle against a rule-level model, plus directed scenarios with literal expectations.
module tb_pipeline_ctrl;

    localparam int A_CNT_W = 4;
    localparam int A_TO    = 16;
    localparam int B_CNT_W = 16;
    localparam int B_TO    = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
    logic       ID_EX_MemRead, EX_MEM_Branch, EX_MEM_ALU_Zero;
    logic       EX_MEM_MemRead, EX_MEM_MemWrite, mem_ready;

    logic a_mem_req, a_pc_w, a_ifid_w, a_idex_w, a_exmem_w, a_memwb_w;
    logic a_ifid_f, a_idex_f, a_exmem_f, a_memwb_f, a_pc_src, a_mem_error;
    logic [A_CNT_W-1:0] a_sc, a_fc;
    logic b_mem_req, b_pc_w, b_ifid_w, b_idex_w, b_exmem_w, b_memwb_w;
    logic b_ifid_f, b_idex_f, b_exmem_f, b_memwb_f, b_pc_src, b_mem_error;
    logic [B_CNT_W-1:0] b_sc, b_fc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(A_CNT_W), .MEM_TIMEOUT(A_TO)) u_dut_a (
        .clk(clk), .reset(reset),
        .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
        .EX_MEM_Branch(EX_MEM_Branch), .EX_MEM_ALU_Zero(EX_MEM_ALU_Zero),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .mem_ready(mem_ready), .mem_req(a_mem_req),
        .PC_Write(a_pc_w), .IF_ID_Write(a_ifid_w), .ID_EX_Write(a_idex_w),
        .EX_MEM_Write(a_exmem_w), .MEM_WB_Write(a_memwb_w),
        .IF_ID_Flush(a_ifid_f), .ID_EX_Flush(a_idex_f), .EX_MEM_Flush(a_exmem_f),
        .MEM_WB_Flush(a_memwb_f), .PC_Src(a_pc_src), .mem_error(a_mem_error),
        .stall_count(a_sc), .flush_count(a_fc)
    );

    pipeline_ctrl #(.CNT_W(B_CNT_W), .MEM_TIMEOUT(B_TO)) u_dut_b (
        .clk(clk), .reset(reset),
        .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
        .EX_MEM_Branch(EX_MEM_Branch), .EX_MEM_ALU_Zero(EX_MEM_ALU_Zero),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .mem_ready(mem_ready), .mem_req(b_mem_req),
        .PC_Write(b_pc_w), .IF_ID_Write(b_ifid_w), .ID_EX_Write(b_idex_w),
        .EX_MEM_Write(b_exmem_w), .MEM_WB_Write(b_memwb_w),
        .IF_ID_Flush(b_ifid_f), .ID_EX_Flush(b_idex_f), .EX_MEM_Flush(b_exmem_f),
        .MEM_WB_Flush(b_memwb_f), .PC_Src(b_pc_src), .mem_error(b_mem_error),
        .stall_count(b_sc), .flush_count(b_fc)
    );

    // Reference model: error flag, consecutive not-ready count and plain integer counters.
    int TO   [2] = '{A_TO, B_TO};
    int MAXC [2] = '{15, 65535};
    bit m_err  [2] = '{1'b0, 1'b0};
    int m_wait [2] = '{0, 0};
    int m_sc   [2] = '{0, 0};
    int m_fc   [2] = '{0, 0};
    bit m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit order: req, PC/IF_ID/ID_EX/EX_MEM/MEM_WB write, IF_ID/ID_EX/EX_MEM/MEM_WB flush, PC_Src, error.
    function automatic logic [11:0] exp_out(input bit err);
        bit req, stall, br, lu;
        logic [11:0] o;
        req   = EX_MEM_MemRead | EX_MEM_MemWrite;
        stall = req & !mem_ready;
        br    = EX_MEM_Branch & EX_MEM_ALU_Zero;
        lu    = ID_EX_MemRead && (ID_EX_Rd != 0) && ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));
        if (reset)      o = {11'b0, err};
        else if (err)   o = {11'b0, 1'b1};
        else if (stall) o = {1'b1, 4'b0000, 1'b1, 3'b000, 1'b1, 2'b00};
        else if (br)    o = {req, 5'b11111, 3'b111, 1'b0, 1'b1, 1'b0};
        else if (lu)    o = {req, 5'b00111, 6'b010000};
        else            o = {req, 5'b11111, 6'b000000};
        return o;
    endfunction

    task automatic model_step(input int k);
        bit req, stall, br, lu;
        req   = EX_MEM_MemRead | EX_MEM_MemWrite;
        stall = req & !mem_ready;
        br    = EX_MEM_Branch & EX_MEM_ALU_Zero;
        lu    = ID_EX_MemRead && (ID_EX_Rd != 0) && ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));
        if (reset) begin
            m_err[k] = 1'b0; m_wait[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end else if (!m_err[k]) begin
            if (stall) begin
                m_wait[k]++;
                if (m_wait[k] >= TO[k]) m_err[k] = 1'b1;
            end else begin
                m_wait[k] = 0;
            end
            if ((stall || (!br && lu)) && m_sc[k] < MAXC[k]) m_sc[k]++;
            if (!stall && br && m_fc[k] < MAXC[k]) m_fc[k]++;
        end
    endtask

    always @(posedge clk) begin
        if (reset) m_valid = 1'b1;
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("a_ctrl", 32'({a_mem_req, a_pc_w, a_ifid_w, a_idex_w, a_exmem_w, a_memwb_w,
                                 a_ifid_f, a_idex_f, a_exmem_f, a_memwb_f, a_pc_src, a_mem_error}),
                  32'(exp_out(m_err[0])));
            check("b_ctrl", 32'({b_mem_req, b_pc_w, b_ifid_w, b_idex_w, b_exmem_w, b_memwb_w,
                                 b_ifid_f, b_idex_f, b_exmem_f, b_memwb_f, b_pc_src, b_mem_error}),
                  32'(exp_out(m_err[1])));
            check("a_stall_count", 32'(a_sc), 32'(m_sc[0]));
            check("a_flush_count", 32'(a_fc), 32'(m_fc[0]));
            check("b_stall_count", 32'(b_sc), 32'(m_sc[1]));
            check("b_flush_count", 32'(b_fc), 32'(m_fc[1]));
        end
    end

    task automatic idle();
        IF_ID_Rs1 = 5'd0; IF_ID_Rs2 = 5'd0; ID_EX_Rd = 5'd0;
        ID_EX_MemRead = 1'b0; EX_MEM_Branch = 1'b0; EX_MEM_ALU_Zero = 1'b0;
        EX_MEM_MemRead = 1'b0; EX_MEM_MemWrite = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use(input logic [4:0] rd);
        ID_EX_MemRead = 1'b1; ID_EX_Rd = rd; IF_ID_Rs2 = 5'd5;
    endtask

    task automatic do_reset();
        reset = 1'b1; idle();
        step();
        reset = 1'b0;
    endtask

    int rdy_pct;

    initial begin
        idle();
        EX_MEM_MemRead = 1'b1;
        step();
        @(negedge clk);
        check("reset_mem_req", 32'(a_mem_req), 32'd0);
        check("reset_pc_write", 32'(a_pc_w), 32'd0);
        step();
        reset = 1'b0; idle();
        @(negedge clk);
        check("post_reset_stall_count", 32'(a_sc), 32'd0);
        check("post_reset_mem_error", 32'(a_mem_error), 32'd0);
        check("post_reset_pc_write", 32'(a_pc_w), 32'd1);

        // Load-use on Rs2, then the same with Rd=0.
        step(); load_use(5'd5);
        @(negedge clk);
        check("lu_pc_write", 32'(a_pc_w), 32'd0);
        check("lu_ifid_write", 32'(a_ifid_w), 32'd0);
        check("lu_idex_flush", 32'(a_idex_f), 32'd1);
        step(); load_use(5'd0);
        @(negedge clk);
        check("lu_rd0_pc_write", 32'(a_pc_w), 32'd1);
        check("lu_stall_count", 32'(a_sc), 32'd1);

        // Taken branch with a concurrent load-use, then an untaken branch.
        step(); load_use(5'd5); EX_MEM_Branch = 1'b1; EX_MEM_ALU_Zero = 1'b1;
        @(negedge clk);
        check("br_pc_src", 32'(a_pc_src), 32'd1);
        check("br_flushes", 32'({a_ifid_f, a_idex_f, a_exmem_f}), 32'b111);
        check("br_pc_write", 32'(a_pc_w), 32'd1);
        step(); idle(); EX_MEM_Branch = 1'b1;
        @(negedge clk);
        check("br_flush_count", 32'(a_fc), 32'd1);
        check("br_stall_count", 32'(a_sc), 32'd1);
        check("nbr_pc_src", 32'(a_pc_src), 32'd0);

        // Memory wait: three not-ready cycles then ready.
        step(); do_reset();
        EX_MEM_MemRead = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mw_memwb_flush", 32'(a_memwb_f), 32'd1);
            check("mw_pc_write", 32'(a_pc_w), 32'd0);
            step();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("mw_done_pc_write", 32'(a_pc_w), 32'd1);
        check("mw_done_memwb_flush", 32'(a_memwb_f), 32'd0);
        check("mw_b_too_late", 32'(b_mem_error), 32'd1);
        step(); idle();
        @(negedge clk);
        check("mw_stall_count", 32'(a_sc), 32'd3);

        // Timeout on the A instance (MEM_TIMEOUT=16).
        step(); do_reset();
        EX_MEM_MemRead = 1'b1; mem_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check("to_no_error_yet", 32'(a_mem_error), 32'd0);
            step();
        end
        @(negedge clk);
        check("to_mem_error", 32'(a_mem_error), 32'd1);
        check("to_mem_req", 32'(a_mem_req), 32'd0);
        check("to_writes", 32'({a_pc_w, a_ifid_w, a_idex_w, a_exmem_w, a_memwb_w}), 32'd0);
        step(); mem_ready = 1'b1;
        @(negedge clk);
        check("to_ready_ignored", 32'(a_mem_error), 32'd1);
        step(); reset = 1'b1;
        step(); reset = 1'b0; idle();
        @(negedge clk);
        check("to_reset_error", 32'(a_mem_error), 32'd0);
        check("to_reset_count", 32'(a_sc), 32'd0);

        // Memory stall outranks load-use; load-use applies once ready arrives.
        step(); EX_MEM_MemWrite = 1'b1; mem_ready = 1'b0;
        ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd7; IF_ID_Rs1 = 5'd7;
        @(negedge clk);
        check("prio_idex_flush", 32'(a_idex_f), 32'd0);
        check("prio_memwb_flush", 32'(a_memwb_f), 32'd1);
        step(); mem_ready = 1'b1;
        @(negedge clk);
        check("prio_lu_after", 32'({a_pc_w, a_ifid_w, a_idex_f}), 32'b001);

        // Saturation: 20 load-use cycles.
        step(); do_reset();
        load_use(5'd5);
        repeat (20) step();
        idle();
        @(negedge clk);
        check("sat_a_stall", 32'(a_sc), 32'd15);
        check("sat_b_stall", 32'(b_sc), 32'd20);

        // Randomised traffic with varying memory responsiveness.
        rdy_pct = 50;
        for (int n = 0; n < 4000; n++) begin
            step();
            if (n % 500 == 0) rdy_pct = (n % 1500 == 0) ? 90 : ((n % 1000 == 0) ? 20 : 60);
            reset           = ($urandom_range(0, 149) == 0);
            IF_ID_Rs1       = 5'($urandom_range(0, 3));
            IF_ID_Rs2       = 5'($urandom_range(0, 3));
            ID_EX_Rd        = 5'($urandom_range(0, 3));
            ID_EX_MemRead   = ($urandom_range(0, 1) == 1);
            EX_MEM_Branch   = ($urandom_range(0, 3) == 0);
            EX_MEM_ALU_Zero = ($urandom_range(0, 1) == 1);
            EX_MEM_MemRead  = ($urandom_range(0, 3) == 0);
            EX_MEM_MemWrite = ($urandom_range(0, 5) == 0);
            mem_ready       = ($urandom_range(0, 99) < rdy_pct);
        end
        step(); reset = 1'b0; idle();
        step();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
